envelope_generator: RTL and testbench

//  Downstream of the oscillator stage: picks one of the oscillator's wavetable outputs and

---
 rtl/envelope_generator.sv | 134 +++++++++++++
 tb/tb_envelope_generator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_generator.sv
// ADSR envelope generator: selects one oscillator wavetable output and scales it by a
// gate-driven amplitude envelope, emitting one sample per audio generation tick.
module envelope_generator #(
    parameter int NUM_WAVETABLES  = 3,
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int ENV_WIDTH       = 16,
    parameter int TICK_DIVIDE     = 1041
) (
    input  logic                                   clock_50_000_000,
    input  logic                                   reset_l,
    input  logic                                   gate,
    input  logic [(NUM_WAVETABLES > 1 ? $clog2(NUM_WAVETABLES) : 1)-1:0] wave_select,
    input  logic [NUM_WAVETABLES-1:0][AUDIO_BIT_WIDTH-1:0] waves,
    input  logic [ENV_WIDTH-1:0]                   attack_step,
    input  logic [ENV_WIDTH-1:0]                   decay_step,
    input  logic [ENV_WIDTH-1:0]                   sustain_level,
    input  logic [ENV_WIDTH-1:0]                   release_step,
    output logic                                   osc_clear,
    output logic [AUDIO_BIT_WIDTH-1:0]             sample,
    output logic                                   sample_valid,
    output logic                                   active
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int CNT_WIDTH  = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
    localparam int PROD_WIDTH = AUDIO_BIT_WIDTH + ENV_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICK_DIVIDE - 1);
    localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = '1;

    logic [2:0]                  state, state_next;
    logic [ENV_WIDTH-1:0]        level, level_next;
    logic [CNT_WIDTH-1:0]        tick_cnt;
    logic                        gate_q;
    logic                        tick, rise, fall, release_req;
    logic [ENV_WIDTH:0]          attack_sum, decay_diff, release_diff;
    logic [AUDIO_BIT_WIDTH-1:0]  wave_word, scaled;
    logic signed [PROD_WIDTH-1:0] product;

    assign tick         = (tick_cnt == TICK_LAST);
    assign rise         = gate & ~gate_q;
    assign fall         = ~gate & gate_q;
    assign release_req  = fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN);

    // one extra bit so carries/borrows are visible before saturating
    assign attack_sum   = {1'b0, level} + {1'b0, attack_step};
    assign decay_diff   = {1'b0, level} - {1'b0, decay_step};
    assign release_diff = {1'b0, level} - {1'b0, release_step};

    always_comb begin
        state_next = state;
        level_next = level;
        if (rise) begin
            state_next = ST_ATTACK;
        end else if (release_req) begin
            state_next = ST_RELEASE;
        end else if (tick) begin
            case (state)
                ST_ATTACK: begin
                    if (attack_step == '0 || attack_sum >= {1'b0, LEVEL_MAX}) begin
                        level_next = LEVEL_MAX;
                        state_next = ST_DECAY;
                    end else begin
                        level_next = attack_sum[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_step == '0 || decay_diff[ENV_WIDTH] ||
                        decay_diff[ENV_WIDTH-1:0] <= sustain_level) begin
                        level_next = sustain_level;
                        state_next = ST_SUSTAIN;
                    end else begin
                        level_next = decay_diff[ENV_WIDTH-1:0];
                    end
                end
                ST_SUSTAIN: level_next = sustain_level;
                ST_RELEASE: begin
                    if (release_step == '0 || release_diff[ENV_WIDTH] ||
                        release_diff[ENV_WIDTH-1:0] == '0) begin
                        level_next = '0;
                        state_next = ST_IDLE;
                    end else begin
                        level_next = release_diff[ENV_WIDTH-1:0];
                    end
                end
                ST_IDLE:    level_next = '0;
                default: begin
                    level_next = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wave_word = '0;
        if (int'(wave_select) < NUM_WAVETABLES) begin
            wave_word = waves[wave_select];
        end
    end

    assign product = $signed(wave_word) * $signed({1'b0, level});
    assign scaled  = AUDIO_BIT_WIDTH'(product >>> ENV_WIDTH);

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ST_IDLE;
            level        <= '0;
            tick_cnt     <= '0;
            gate_q       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            osc_clear    <= 1'b0;
            active       <= 1'b0;
        end else begin
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            gate_q       <= gate;
            state        <= state_next;
            level        <= level_next;
            osc_clear    <= rise;
            sample_valid <= tick;
            // active follows the registered state, so it lags the IDLE entry by a cycle
            active       <= (state != ST_IDLE);
            if (tick) begin
                sample <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_envelope_generator.sv
// Directed self-checking bench for envelope_generator with a 4-clock audio tick.
module tb_envelope_generator;

    logic                  clock_50_000_000 = 1'b0;
    logic                  reset_l;
    logic                  gate;
    logic [1:0]            wave_select;
    logic [2:0][23:0]      waves;
    logic [15:0]           attack_step, decay_step, sustain_level, release_step;
    logic                  osc_clear;
    logic [23:0]           sample;
    logic                  sample_valid;
    logic                  active;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // wave 0 = 1.0 in Q16, so the sample reads back the pre-tick level directly
    logic [23:0] ramp_exp [13] = '{24'h000000, 24'h004000, 24'h008000, 24'h00C000,
                                   24'h00FFFF, 24'h00EFFF, 24'h00DFFF, 24'h00CFFF,
                                   24'h00BFFF, 24'h00AFFF, 24'h009FFF, 24'h008FFF,
                                   24'h008000};
    logic [23:0] note_exp [5]  = '{24'h000000, 24'h004000, 24'h008000, 24'h00C000,
                                   24'h00FFFF};

    envelope_generator #(
        .NUM_WAVETABLES (3),
        .AUDIO_BIT_WIDTH(24),
        .ENV_WIDTH      (16),
        .TICK_DIVIDE    (4)
    ) dut (
        .clock_50_000_000(clock_50_000_000),
        .reset_l         (reset_l),
        .gate            (gate),
        .wave_select     (wave_select),
        .waves           (waves),
        .attack_step     (attack_step),
        .decay_step      (decay_step),
        .sustain_level   (sustain_level),
        .release_step    (release_step),
        .osc_clear       (osc_clear),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .active          (active)
    );

    always #5 clock_50_000_000 = ~clock_50_000_000;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step_clock();
        @(posedge clock_50_000_000);
        #1;
    endtask

    task automatic next_sample(input string tag, output logic [23:0] s);
        logic found;
        found = 1'b0;
        s = 'x;
        for (int i = 0; i < 12 && !found; i++) begin
            step_clock();
            if (sample_valid) begin
                found = 1'b1;
                s = sample;
            end
        end
        if (!found) check_value({tag, "_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic check_next(input string tag, input logic [23:0] exp);
        logic [23:0] s;
        next_sample(tag, s);
        check_value(tag, s, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_sample"}, sample, 24'h0);
        check_value({tag, "_valid"}, sample_valid, 1'b0);
        check_value({tag, "_osc_clear"}, osc_clear, 1'b0);
        check_value({tag, "_active"}, active, 1'b0);
    endtask

    task automatic release_reset_and_count(input string tag);
        int unsigned n;
        reset_l = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step_clock();
            n++;
            if (sample_valid) break;
        end
        check_value({tag, "_first_valid_clocks"}, n, 4);
        check_value({tag, "_first_sample"}, sample, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [23:0] s;
        reset_l       = 1'b0;
        gate          = 1'b0;
        wave_select   = 2'd0;
        waves[0]      = 24'h010000;
        waves[1]      = 24'h800000;
        waves[2]      = 24'h7FFFFF;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'h8000;
        release_step  = 16'h7000;

        repeat (3) step_clock();
        check_reset_outputs("por");
        release_reset_and_count("por");

        // note 1: attack ramp, decay landing on sustain, live sustain tracking
        gate = 1'b1;
        step_clock();
        check_value("osc_clear_on", osc_clear, 1'b1);
        step_clock();
        check_value("osc_clear_off", osc_clear, 1'b0);
        check_value("active_attack", active, 1'b1);
        foreach (ramp_exp[i]) check_next($sformatf("ramp%0d", i), ramp_exp[i]);
        sustain_level = 16'h6000;
        check_next("sustain_old", 24'h008000);
        check_next("sustain_new", 24'h006000);

        // full-scale level for the scaling checks
        sustain_level = 16'hFFFF;
        check_next("sustain_full", 24'h006000);
        wave_select = 2'd2;
        check_next("scale_pos_max", 24'h7FFF7F);
        wave_select = 2'd1;
        check_next("scale_neg_max", 24'h800080);
        wave_select = 2'd3;
        check_next("scale_bad_sel", 24'h000000);
        wave_select = 2'd0;
        check_next("scale_unity", 24'h00FFFF);

        // release_step of 0 drops straight to silence
        release_step = 16'h0000;
        gate = 1'b0;
        check_next("rel0_tick", 24'h00FFFF);
        check_value("rel0_active_lag", active, 1'b1);
        step_clock();
        check_value("rel0_active_drop", active, 1'b0);
        check_next("rel0_idle", 24'h000000);

        // note 2: gate falls in DECAY at 0xA000
        decay_step    = 16'h5FFF;
        sustain_level = 16'h1000;
        release_step  = 16'h7000;
        gate = 1'b1;
        foreach (note_exp[i]) check_next($sformatf("n2_%0d", i), note_exp[i]);
        gate = 1'b0;
        check_next("n2_rel_a", 24'h00A000);
        check_next("n2_rel_b", 24'h003000);
        check_value("n2_active_lag", active, 1'b1);
        step_clock();
        check_value("n2_active_drop", active, 1'b0);
        check_next("n2_idle", 24'h000000);

        // note 3: retrigger in RELEASE coincident with a tick
        release_step = 16'h8000;
        gate = 1'b1;
        foreach (note_exp[i]) check_next($sformatf("n3_%0d", i), note_exp[i]);
        gate = 1'b0;
        check_next("n3_rel", 24'h00A000);
        repeat (3) step_clock();
        gate = 1'b1;
        step_clock();
        check_value("n3_retrig_valid", sample_valid, 1'b1);
        check_value("n3_retrig_sample", sample, 24'h002000);
        check_value("n3_retrig_osc", osc_clear, 1'b1);
        check_next("n3_hold", 24'h002000);
        check_next("n3_step", 24'h006000);

        // asynchronous reset mid-ATTACK
        reset_l = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        gate = 1'b0;
        step_clock();
        check_reset_outputs("mid_rst_held");
        release_reset_and_count("mid_rst");
        check_value("mid_rst_active", active, 1'b0);

        // zero attack/decay steps jump straight to their targets
        attack_step   = 16'h0000;
        decay_step    = 16'h0000;
        sustain_level = 16'h3000;
        gate = 1'b1;
        check_next("zero_a", 24'h000000);
        check_next("zero_b", 24'h00FFFF);
        check_next("zero_c", 24'h003000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
